// File: rtl/counter_pkg.sv
// Shared counter-library definitions: JK cell encodings, direction codes and
// the JK next-state helper used by every storage cell.
package counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic nxt;
        case (jk)
            JK_HOLD:   nxt = q;
            JK_RESET:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit with asynchronous active-low reset to 0.
module jk_cell
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // JK state update from the {j,k} encoding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else begin
            q_r <= jk_next(q_r, {j, k});
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jk_updown_counter.sv
// Parametrised up/down modulo counter built from a row of JK cells, with
// clear, saturating load, terminal count and a registered wrap pulse.
module jk_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT_C = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] t_step_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] load_sat_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             force_s;
    logic             wrap_next_s;
    logic             wrap_r;

    assign at_max_s  = (count_s == MAX_VAL_C);
    assign at_zero_s = (count_s == {WIDTH{1'b0}});

    // Ripple toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic carry_v;
        carry_v  = 1'b1;
        t_step_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            t_step_s[i] = carry_v;
            if (up_dn == DIR_UP) begin
                carry_v = carry_v & count_s[i];
            end else begin
                carry_v = carry_v & ~count_s[i];
            end
        end
    end

    // Out-of-range load values clamp to the top of the count range
    always_comb begin
        if ({1'b0, load_val} < MOD_EXT_C) begin
            load_sat_s = load_val;
        end else begin
            load_sat_s = MAX_VAL_C;
        end
    end

    // Priority clr > load > count; wraps take the forced-value path
    always_comb begin
        force_s     = 1'b0;
        d_s         = {WIDTH{1'b0}};
        t_s         = {WIDTH{1'b0}};
        wrap_next_s = 1'b0;
        if (clr) begin
            force_s = 1'b1;
        end else if (load) begin
            force_s = 1'b1;
            d_s     = load_sat_s;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_max_s) begin
                    force_s     = 1'b1;
                    wrap_next_s = 1'b1;
                end else begin
                    t_s = t_step_s;
                end
            end else begin
                if (at_zero_s) begin
                    force_s     = 1'b1;
                    d_s         = MAX_VAL_C;
                    wrap_next_s = 1'b1;
                end else begin
                    t_s = t_step_s;
                end
            end
        end else begin
            t_s = {WIDTH{1'b0}};
        end
    end

    assign j_s = force_s ? d_s  : t_s;
    assign k_s = force_s ? ~d_s : t_s;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_s[gi]),
            .k     (k_s[gi]),
            .q     (count_s[gi])
        );
    end

    // Wrap pulse register, cleared by reset so a pending pulse is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_next_s;
        end
    end

    assign count     = count_s;
    assign count_bar = ~count_s;
    assign tc        = en & ((up_dn & at_max_s) | (~up_dn & at_zero_s));
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: four configurations driven in parallel and
// compared against an arithmetic modulo-counter model.
module tb_jk_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;

    logic [2:0] cnt0, bar0;
    logic [2:0] cnt1, bar1;
    logic [3:0] cnt2, bar2;
    logic [0:0] cnt3, bar3;
    logic       tc0, tc1, tc2, tc3;
    logic       wrap0, wrap1, wrap2, wrap3;

    int n_checks = 0;
    int n_fail   = 0;
    int mcnt[4];
    int mwrap[4];
    int mods[4] = '{8, 6, 16, 2};
    int wids[4] = '{3, 3, 4, 1};

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[2:0]), .count(cnt0), .count_bar(bar0), .tc(tc0), .wrap(wrap0));
    jk_updown_counter #(.WIDTH(3), .MODULUS(6)) u_m6 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[2:0]), .count(cnt1), .count_bar(bar1), .tc(tc1), .wrap(wrap1));
    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(cnt2), .count_bar(bar2), .tc(tc2), .wrap(wrap2));
    jk_updown_counter #(.WIDTH(1), .MODULUS(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[0:0]), .count(cnt3), .count_bar(bar3), .tc(tc3), .wrap(wrap3));

    function automatic int obs_count(int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            3: return int'(cnt3);
            default: return -1;
        endcase
    endfunction

    function automatic int obs_bar(int i);
        case (i)
            0: return int'(bar0);
            1: return int'(bar1);
            2: return int'(bar2);
            3: return int'(bar3);
            default: return -1;
        endcase
    endfunction

    function automatic int obs_tc(int i);
        case (i)
            0: return int'(tc0);
            1: return int'(tc1);
            2: return int'(tc2);
            3: return int'(tc3);
            default: return -1;
        endcase
    endfunction

    function automatic int obs_wrap(int i);
        case (i)
            0: return int'(wrap0);
            1: return int'(wrap1);
            2: return int'(wrap2);
            3: return int'(wrap3);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string phase);
        for (int i = 0; i < 4; i++) begin
            int mask;
            int exp_tc;
            mask   = (1 << wids[i]) - 1;
            exp_tc = (en && (up_dn ? (mcnt[i] == mods[i] - 1) : (mcnt[i] == 0))) ? 1 : 0;
            check($sformatf("%s count M%0d", phase, mods[i]), obs_count(i), mcnt[i]);
            check($sformatf("%s count_bar M%0d", phase, mods[i]), obs_bar(i), (~mcnt[i]) & mask);
            check($sformatf("%s wrap M%0d", phase, mods[i]), obs_wrap(i), mwrap[i]);
            check($sformatf("%s tc M%0d", phase, mods[i]), obs_tc(i), exp_tc);
        end
    endtask

    // Reference behaviour: plain modulo arithmetic with the stated priorities
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            int lv;
            lv = int'(load_val) & ((1 << wids[i]) - 1);
            mwrap[i] = 0;
            if (clr) begin
                mcnt[i] = 0;
            end else if (load) begin
                mcnt[i] = (lv < mods[i]) ? lv : mods[i] - 1;
            end else if (en) begin
                if (up_dn) begin
                    if (mcnt[i] == mods[i] - 1) begin
                        mcnt[i] = 0;
                        mwrap[i] = 1;
                    end else begin
                        mcnt[i] = mcnt[i] + 1;
                    end
                end else begin
                    if (mcnt[i] == 0) begin
                        mcnt[i] = mods[i] - 1;
                        mwrap[i] = 1;
                    end else begin
                        mcnt[i] = mcnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                         input logic [3:0] lv);
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        #1;
        check_all("pre");
        @(posedge clk);
        model_edge();
        #1;
        check_all("post");
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            mcnt[i]  = 0;
            mwrap[i] = 0;
        end
        check_all("rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mcnt[i]  = 0;
            mwrap[i] = 0;
        end
        #1;
        check_all("init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Mid-count reset with a pending wrap pulse on the modulus-2 counter
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Up wrap from 0, then down wrap from 2
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int n = 0; n < 7; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Load, saturation and load-over-count priority
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);

        // Clear beats load and count even while tc is high
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd4);

        // Power-of-two rollover and direction flip
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd14);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Randomised traffic with occasional asynchronous resets
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(3, 0) != 0),
                  1'($urandom_range(1, 0)),
                  ($urandom_range(19, 0) == 0),
                  ($urandom_range(9, 0) == 0),
                  4'($urandom_range(15, 0)));
            if ($urandom_range(49, 0) == 0) begin
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_updown_counter.md
# jk_updown_counter

Parametrised synchronous up/down counter built from a row of JK storage cells, generalising the 3-bit JK up counter.
- Adds width and modulus parameters, direction control, clock enable, synchronous clear, parallel load, terminal-count output and a registered wrap pulse.
- Sits in the counter library as the general-purpose counting primitive for dividers, sequencers and test fixtures.

## Interface
Parameters:
- WIDTH, 3, counter width in bits (1..16)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1 (2..2**WIDTH)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable
- up_dn  input  1  1 = count up, 0 = count down
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- count  output  WIDTH  current count (registered)
- count_bar  output  WIDTH  bitwise ~count
- tc  output  1  terminal count (combinational)
- wrap  output  1  one-cycle registered pulse after a wrap

## Operation
- Reset: rst_n low forces count=0 and wrap=0 immediately, independent of clk. Consequently count_bar=all ones and tc=(en & ~up_dn). On release, the counter resumes at the first rising edge where rst_n is high.
- Per-edge priority: clr > load > en count > hold.
- clr=1: count<=0; wrap<=0.
- load=1 (clr=0): count<=load_val if load_val<MODULUS, else count<=MODULUS-1 (saturate); wrap<=0.
- en=1 with up_dn=1:
  - count<=count+1 if count<MODULUS-1.
  - If count==MODULUS-1, count<=0 and wrap<=1.
- en=1 with up_dn=0:
  - count<=count-1 if count>0.
  - If count==0, count<=MODULUS-1 and wrap<=1.
- en=0: count holds; wrap<=0.
- wrap is 0 on every edge that is not a wrap event. It is therefore a single-cycle pulse, or stays high across consecutive wraps (e.g. MODULUS=2).
- tc = en & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)). tc is the wrap-enable for cascading; it ignores clr and load.
- Bit update mechanism:
  - Plain step: each cell uses J=K=t_i.
    - Up: t_i = AND of count[i-1:0].
    - Down: t_i = AND of ~count[i-1:0].
    - t_0 = 1.
  - Forced value d (clear, load, modulus wrap, power-of-two rollover): J=d_i, K=~d_i.
  - When MODULUS==2**WIDTH the natural toggle rollover equals the wrap value. Either path is legal; the result must be identical.
- Changing up_dn mid-count takes effect on the next enabled edge with no extra latency.

## Timing
- count, count_bar: one-edge latency from clr/load/en; count_bar is combinational from count.
- wrap: asserted on the same edge count wraps, visible for exactly one cycle per wrap event.
- tc: purely combinational from en, up_dn and count. The only timing path is count-register to tc to downstream en.
- Reset assertion mid-count: outputs go to their reset values asynchronously, and a pending wrap pulse is cancelled.

## Structure
- Sub-module jk_cell: one JK storage bit.
  - Inputs: clk, rst_n, j, k.
  - Output: q.
  - Async active-low reset to 0; JK truth table 00 hold, 01 reset, 10 set, 11 toggle.
  - The counter instantiates WIDTH cells via generate.
- The wrap pulse is a plain flop in the top level.
- Shared package counter_pkg:
  - JK encoding constants JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE.
  - Direction constants DIR_DOWN=0, DIR_UP=1.
- The package is reused by the other counter-library blocks.

## Test plan
- Reset and hold (WIDTH=3, MODULUS=8):
  - rst_n=0 mid-count at count=5: count=0, count_bar=7 and wrap=0 immediately, before any edge.
  - Release with en=0: count stays 0.
- Up wrap (MODULUS=6):
  - en=1, up_dn=1 from 0 for 7 edges: count 1,2,3,4,5,0,1.
  - tc=1 only while count=5.
  - wrap=1 only in the cycle following 5 to 0.
- Down wrap (MODULUS=6):
  - en=1, up_dn=0 from 2 for 4 edges: count 1,0,5,4.
  - tc=1 while count=0.
  - wrap pulses once after the 0 to 5 transition.
- Load and saturation (MODULUS=6):
  - load_val=3 gives count=3.
  - load_val=7 gives count=5.
  - load and en both high: load wins, no increment that edge.
- Priority (MODULUS=8):
  - clr=1, load=1, load_val=4, en=1 at count=7, up: count=0, wrap=0, even though tc=1 that cycle.
- Power-of-two and direction flip (WIDTH=4, MODULUS=16):
  - Up from 14: 15, 0 with wrap.
  - Then up_dn=0: 15 with wrap, then 14.
